switch_control: RTL and testbench

//  Router-level scheduler for the five input fifo_buffer instances of a Phoenix router.

---
 rtl/switch_control_pkg.sv | 24 ++
 rtl/switch_control_arbiter.sv | 41 ++++
 rtl/switch_control.sv | 156 +++++++++++++++
 tb/tb_switch_control.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_control_pkg.sv
// Shared port indices, widths and state encodings for the Phoenix router switch control.
package switch_control_pkg;
    localparam int WIDTH = 16;
    localparam int NPORT = 5;
    localparam int PW    = 3;

    localparam logic [PW-1:0] EAST  = 3'd0;
    localparam logic [PW-1:0] WEST  = 3'd1;
    localparam logic [PW-1:0] NORTH = 3'd2;
    localparam logic [PW-1:0] SOUTH = 3'd3;
    localparam logic [PW-1:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2
    } sw_state_t;

    typedef enum logic [1:0] {
        P_HDR  = 2'd0,
        P_SIZE = 2'd1,
        P_PAY  = 2'd2
    } pkt_phase_t;
endpackage

// File: rtl/switch_control_arbiter.sv
// Round-robin arbiter over the router inputs; the pointer remembers the last winner
// and only moves when the caller pulses en.
module round_robin_arbiter
    import switch_control_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [NPORT-1:0] req,
    input  logic             en,
    output logic [NPORT-1:0] grant,
    output logic [PW-1:0]    grant_idx,
    output logic             valid
);
    logic [PW-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority.
        for (int k = 1; k <= NPORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
        if (valid) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= LOCAL;
        end else if (en && valid) begin
            ptr <= grant_idx;
        end
    end
endmodule

// File: rtl/switch_control.sv
// Router-level scheduler: arbitrates header requests, reserves the XY output port and
// frees it once the packet's last flit has been pulled from the input buffer.
//
//  state   | meaning
//  S_IDLE  | wait for an unrouted header on a free input
//  S_ARB   | pick the next requester round-robin, latch its target address
//  S_ROUTE | compute XY output; grant if that output is free, else drop and retry later
module switch_control
    import switch_control_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             addr,
    input  logic [NPORT-1:0]       req_h,
    input  logic [NPORT*WIDTH-1:0] head,
    input  logic [NPORT-1:0]       pull,
    output logic [NPORT-1:0]       ack_h,
    output logic [NPORT*3-1:0]     out_of_in,
    output logic [NPORT*3-1:0]     in_of_out,
    output logic [NPORT-1:0]       in_busy,
    output logic [NPORT-1:0]       out_busy
);
    function automatic logic [PW-1:0] xy_route(input logic [7:0] here, input logic [7:0] tgt);
        if (tgt[7:4] > here[7:4]) return EAST;
        if (tgt[7:4] < here[7:4]) return WEST;
        if (tgt[3:0] > here[3:0]) return NORTH;
        if (tgt[3:0] < here[3:0]) return SOUTH;
        return LOCAL;
    endfunction

    sw_state_t        state, state_nxt;
    logic [NPORT-1:0] eligible, arb_grant, sel_1h, dst_1h, rel, rel_out;
    logic [PW-1:0]    arb_idx, sel, dst;
    logic             arb_valid, arb_en, grant_ok;
    logic [7:0]       target;
    logic [PW-1:0]    oi_r [NPORT];
    logic [PW-1:0]    io_r [NPORT];
    pkt_phase_t       phase [NPORT];
    logic [WIDTH-1:0] cnt [NPORT];

    assign eligible = req_h & ~in_busy;

    round_robin_arbiter u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (eligible),
        .en        (arb_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        case (state)
            S_IDLE:  if (|eligible) state_nxt = S_ARB;
            S_ARB: begin
                arb_en    = 1'b1;
                state_nxt = arb_valid ? S_ROUTE : S_IDLE;
            end
            S_ROUTE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dst      = xy_route(addr, target);
    assign dst_1h   = NPORT'(1) << dst;
    // out_busy is the registered value, so an output freed this cycle is not reusable yet.
    assign grant_ok = (state == S_ROUTE) && !out_busy[dst];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            sel    <= '0;
            sel_1h <= '0;
            target <= '0;
        end else begin
            state <= state_nxt;
            if (arb_en && arb_valid) begin
                sel    <= arb_idx;
                sel_1h <= arb_grant;
                target <= head[int'(arb_idx)*WIDTH +: 8];
            end
        end
    end

    always_comb begin
        rel     = '0;
        rel_out = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (pull[i] && in_busy[i]) begin
                if ((phase[i] == P_SIZE && head[i*WIDTH +: WIDTH] == '0) ||
                    (phase[i] == P_PAY && cnt[i] == WIDTH'(1)))
                    rel[i] = 1'b1;
            end
            if (rel[i]) rel_out[oi_r[i]] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_h    <= '0;
            in_busy  <= '0;
            out_busy <= '0;
            for (int i = 0; i < NPORT; i++) begin
                oi_r[i] <= '0;
                io_r[i] <= '0;
            end
        end else begin
            ack_h    <= grant_ok ? sel_1h : '0;
            in_busy  <= (in_busy & ~rel) | (grant_ok ? sel_1h : '0);
            out_busy <= (out_busy & ~rel_out) | (grant_ok ? dst_1h : '0);
            if (grant_ok) begin
                oi_r[sel] <= dst;
                io_r[dst] <= sel;
            end
        end
    end

    // Flit counting: header, size flit carrying N, then N payload flits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORT; i++) begin
                phase[i] <= P_HDR;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (pull[i] && in_busy[i]) begin
                    case (phase[i])
                        P_HDR: phase[i] <= P_SIZE;
                        P_SIZE: begin
                            cnt[i]   <= head[i*WIDTH +: WIDTH];
                            phase[i] <= (head[i*WIDTH +: WIDTH] == '0) ? P_HDR : P_PAY;
                        end
                        P_PAY: begin
                            cnt[i] <= cnt[i] - WIDTH'(1);
                            if (cnt[i] == WIDTH'(1)) phase[i] <= P_HDR;
                        end
                        default: phase[i] <= P_HDR;
                    endcase
                end
            end
        end
    end

    always_comb begin
        out_of_in = '0;
        in_of_out = '0;
        for (int i = 0; i < NPORT; i++) begin
            out_of_in[i*3 +: 3] = oi_r[i];
            in_of_out[i*3 +: 3] = io_r[i];
        end
    end
endmodule

// File: tb/tb_switch_control.sv
// Self-checking bench for switch_control: directed scenarios plus a randomized
// scoreboard run that tracks connections at the packet level.
module tb_switch_control;
    import switch_control_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [7:0]             addr;
    logic [NPORT-1:0]       req_h, pull, ack_h, in_busy, out_busy;
    logic [NPORT*WIDTH-1:0] head;
    logic [NPORT*3-1:0]     out_of_in, in_of_out;
    logic [WIDTH-1:0]       hd [NPORT];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always_comb begin
        head = '0;
        for (int i = 0; i < NPORT; i++) head[i*WIDTH +: WIDTH] = hd[i];
    end

    switch_control dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .req_h     (req_h),
        .head      (head),
        .pull      (pull),
        .ack_h     (ack_h),
        .out_of_in (out_of_in),
        .in_of_out (in_of_out),
        .in_busy   (in_busy),
        .out_busy  (out_busy)
    );

    function automatic logic [2:0] ooi(input int i);
        return out_of_in[i*3 +: 3];
    endfunction

    function automatic logic [2:0] ioo(input int o);
        return in_of_out[o*3 +: 3];
    endfunction

    // XY rule from the address differences.
    function automatic logic [2:0] ref_route(input logic [7:0] here, input logic [7:0] tgt);
        int dx, dy;
        dx = int'(tgt[7:4]) - int'(here[7:4]);
        dy = int'(tgt[3:0]) - int'(here[3:0]);
        if (dx > 0) return EAST;
        if (dx < 0) return WEST;
        if (dy > 0) return NORTH;
        if (dy < 0) return SOUTH;
        return LOCAL;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        req_h = '0;
        pull  = '0;
        for (int i = 0; i < NPORT; i++) hd[i] = '0;
        #4;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({ack_h, in_busy, out_busy, out_of_in, in_of_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b in_busy=%b out_busy=%b ooi=%h ioo=%h, required all 0",
                     ack_h, in_busy, out_busy, out_of_in, in_of_out);
        end
    endtask

    task automatic test_single_grant();
        logic [NPORT-1:0] exp;
        do_reset();
        addr = 8'h11;
        hd[LOCAL] = 16'h0031;
        req_h = 5'b10000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp = (c == 3) ? 5'b10000 : 5'b00000;
            checks++;
            if (ack_h !== exp) begin
                errors++;
                $display("FAIL single_ack cycle %0d: ack_h=%b required %b", c, ack_h, exp);
            end
        end
        req_h = '0;
        checks++;
        if (out_busy !== 5'b00001 || in_busy !== 5'b10000) begin
            errors++;
            $display("FAIL single_busy: out_busy=%b in_busy=%b required 00001 10000", out_busy, in_busy);
        end
        checks++;
        if (ioo(EAST) !== LOCAL || ooi(LOCAL) !== EAST) begin
            errors++;
            $display("FAIL single_tables: in_of_out[E]=%0d out_of_in[L]=%0d required 4 0", ioo(EAST), ooi(LOCAL));
        end
        tick();
        checks++;
        if (ack_h !== '0) begin
            errors++;
            $display("FAIL single_ack_pulse: ack_h=%b required 00000", ack_h);
        end
    endtask

    task automatic test_packet_release();
        for (int p = 1; p <= 5; p++) begin
            repeat ($urandom_range(0, 2)) tick();
            pull[LOCAL] = 1'b1;
            hd[LOCAL] = (p == 1) ? 16'h0031 : (p == 2) ? 16'd3 : 16'($urandom);
            tick();
            pull = '0;
            if (p < 5) begin
                checks++;
                if (out_busy !== 5'b00001 || in_busy !== 5'b10000) begin
                    errors++;
                    $display("FAIL packet_hold pull %0d: out_busy=%b in_busy=%b required 00001 10000", p, out_busy, in_busy);
                end
            end
        end
        checks++;
        if (out_busy !== '0 || in_busy !== '0) begin
            errors++;
            $display("FAIL packet_release: out_busy=%b in_busy=%b required 0 0", out_busy, in_busy);
        end
        pull[LOCAL] = 1'b1;
        hd[LOCAL] = 16'($urandom);
        tick();
        pull = '0;
        checks++;
        if (out_busy !== '0 || in_busy !== '0 || ack_h !== '0) begin
            errors++;
            $display("FAIL idle_pull: out_busy=%b in_busy=%b ack=%b required all 0", out_busy, in_busy, ack_h);
        end
    endtask

    task automatic wait_ack(input string name, input logic [NPORT-1:0] exp);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            tick();
            if (ack_h !== '0) begin
                got = 1'b1;
                lat = c;
            end
        end
        checks++;
        if (!got || ack_h !== exp || lat < 1 || lat > 3) begin
            errors++;
            $display("FAIL %s: ack_h=%b after %0d cycles required %b within 1..3 cycles of release", name, ack_h, lat, exp);
        end
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        addr = 8'h11;
        hd[EAST] = 16'h0011;
        hd[WEST] = 16'h0011;
        req_h = 5'b00011;
        repeat (3) tick();
        checks++;
        if (ack_h !== 5'b00001) begin
            errors++;
            $display("FAIL contend_first: ack_h=%b required 00001", ack_h);
        end
        req_h[EAST] = 1'b0;
        n = $urandom_range(0, 4);
        for (int p = 0; p < n + 2; p++) begin
            pull[EAST] = 1'b1;
            hd[EAST] = (p == 0) ? 16'h0011 : (p == 1) ? 16'(n) : 16'($urandom);
            tick();
            pull = '0;
            checks++;
            if (ack_h !== '0) begin
                errors++;
                $display("FAIL contend_early pull %0d: ack_h=%b required 00000", p, ack_h);
            end
        end
        checks++;
        if (out_busy !== '0 || in_busy !== '0) begin
            errors++;
            $display("FAIL contend_release n=%0d: out_busy=%b in_busy=%b required 0 0", n, out_busy, in_busy);
        end
        wait_ack("contend_second", 5'b00010);
        req_h = '0;
        checks++;
        if (out_busy !== 5'b10000 || ioo(LOCAL) !== WEST || ooi(WEST) !== LOCAL) begin
            errors++;
            $display("FAIL contend_tables: out_busy=%b in_of_out[L]=%0d out_of_in[W]=%0d required 10000 1 4",
                     out_busy, ioo(LOCAL), ooi(WEST));
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        addr = 8'h22;
        hd[SOUTH] = 16'h0025;
        hd[LOCAL] = 16'h0024;
        req_h = 5'b11000;
        repeat (3) tick();
        checks++;
        if (ack_h !== 5'b01000 || out_busy !== 5'b00100) begin
            errors++;
            $display("FAIL zero_grant: ack_h=%b out_busy=%b required 01000 00100", ack_h, out_busy);
        end
        req_h[SOUTH] = 1'b0;
        pull[SOUTH] = 1'b1;
        tick();
        checks++;
        if (out_busy !== 5'b00100) begin
            errors++;
            $display("FAIL zero_first_pull: out_busy=%b required 00100", out_busy);
        end
        hd[SOUTH] = 16'h0000;
        tick();
        pull = '0;
        checks++;
        if (out_busy !== '0 || ack_h !== '0) begin
            errors++;
            $display("FAIL zero_release: out_busy=%b ack=%b required 0 0", out_busy, ack_h);
        end
        wait_ack("zero_held_header", 5'b10000);
        req_h = '0;
        checks++;
        if (out_busy !== 5'b00100 || ioo(NORTH) !== LOCAL) begin
            errors++;
            $display("FAIL zero_reuse: out_busy=%b in_of_out[N]=%0d required 00100 4", out_busy, ioo(NORTH));
        end
    endtask

    task automatic test_four_way();
        logic [2:0] dmap [4];
        logic [7:0] tgt_of [4];
        logic [2:0] tmp;
        logic [NPORT-1:0] exp;
        int j;
        tgt_of = '{8'h32, 8'h12, 8'h23, 8'h21};
        for (int k = 0; k < 4; k++) dmap[k] = 3'(k);
        for (int k = 3; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = dmap[k];
            dmap[k] = dmap[j];
            dmap[j] = tmp;
        end
        do_reset();
        addr = 8'h22;
        for (int i = 0; i < 4; i++) hd[i] = {8'h00, tgt_of[dmap[i]]};
        req_h = 5'b01111;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = (t % 3 == 0) ? (5'b00001 << (t / 3 - 1)) : 5'b00000;
            checks++;
            if (ack_h !== exp) begin
                errors++;
                $display("FAIL four_ack cycle %0d: ack_h=%b required %b", t, ack_h, exp);
            end
            req_h = req_h & ~ack_h;
        end
        checks++;
        if (in_busy !== 5'b01111 || out_busy !== 5'b01111) begin
            errors++;
            $display("FAIL four_busy: in_busy=%b out_busy=%b required 01111 01111", in_busy, out_busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ooi(i) !== dmap[i] || ioo(int'(dmap[i])) !== 3'(i)) begin
                errors++;
                $display("FAIL four_tables in %0d: out_of_in=%0d in_of_out=%0d required %0d %0d",
                         i, ooi(i), ioo(int'(dmap[i])), dmap[i], i);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [NPORT-1:0] exp;
        do_reset();
        addr = 8'h11;
        hd[NORTH] = 16'h0010;
        req_h = 5'b00100;
        repeat (3) tick();
        checks++;
        if (ack_h !== 5'b00100 || out_busy !== 5'b01000) begin
            errors++;
            $display("FAIL arst_grant: ack_h=%b out_busy=%b required 00100 01000", ack_h, out_busy);
        end
        req_h = '0;
        for (int p = 0; p < 3; p++) begin
            pull[NORTH] = 1'b1;
            hd[NORTH] = (p == 0) ? 16'h0010 : (p == 1) ? 16'd5 : 16'($urandom);
            tick();
            pull = '0;
        end
        checks++;
        if (in_busy !== 5'b00100) begin
            errors++;
            $display("FAIL arst_midpacket: in_busy=%b required 00100", in_busy);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({ack_h, in_busy, out_busy, out_of_in, in_of_out} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: ack=%b in_busy=%b out_busy=%b ooi=%h ioo=%h required all 0",
                     ack_h, in_busy, out_busy, out_of_in, in_of_out);
        end
        #2;
        reset = 1'b1;
        hd[NORTH] = 16'h0010;
        req_h = 5'b00100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp = (c == 3) ? 5'b00100 : 5'b00000;
            checks++;
            if (ack_h !== exp) begin
                errors++;
                $display("FAIL arst_regrant cycle %0d: ack_h=%b required %b", c, ack_h, exp);
            end
        end
        req_h = '0;
    endtask

    task automatic test_random();
        logic [7:0]       hdr [NPORT];
        int               n [NPORT];
        int               done [NPORT];
        bit               active [NPORT];
        bit               m_in [NPORT];
        logic [2:0]       m_dst [NPORT];
        bit               m_out [NPORT];
        bit               m_out_pre [NPORT];
        logic [NPORT-1:0] pull_pre, allowed, exp_in, exp_out;
        logic [2:0]       d;
        bit               draining, pending;
        do_reset();
        addr = 8'($urandom);
        for (int i = 0; i < NPORT; i++) begin
            active[i] = 0;
            m_in[i]   = 0;
            m_out[i]  = 0;
            m_dst[i]  = '0;
            done[i]   = 0;
            n[i]      = 0;
            hdr[i]    = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            draining = (cyc >= 2500);
            for (int i = 0; i < NPORT; i++) begin
                if (!active[i] && !draining && $urandom_range(0, 7) == 0) begin
                    active[i] = 1;
                    hdr[i]    = 8'($urandom);
                    n[i]      = $urandom_range(0, 3);
                    req_h[i]  = 1'b1;
                    hd[i]     = {8'($urandom), hdr[i]};
                end
                pull[i] = 1'b0;
                if (m_in[i]) begin
                    pull[i] = 1'($urandom_range(0, 1));
                    hd[i] = (done[i] == 0) ? {8'h00, hdr[i]} : (done[i] == 1) ? 16'(n[i]) : 16'($urandom);
                end else if (!active[i] && $urandom_range(0, 7) == 0) begin
                    pull[i] = 1'b1;
                    hd[i]   = 16'($urandom);
                end
            end
            pull_pre = pull;
            for (int i = 0; i < NPORT; i++) begin
                m_out_pre[i] = m_out[i];
                allowed[i]   = req_h[i] && !m_in[i];
            end
            tick();
            for (int i = 0; i < NPORT; i++) begin
                if (m_in[i] && pull_pre[i]) begin
                    done[i]++;
                    if (done[i] == n[i] + 2) begin
                        m_in[i] = 0;
                        m_out[m_dst[i]] = 0;
                        active[i] = 0;
                    end
                end
            end
            checks++;
            if ((ack_h & ~allowed) !== '0 || !$onehot0(ack_h)) begin
                errors++;
                $display("FAIL rand_ack_legal cycle %0d: ack_h=%b allowed %b (at most one)", cyc, ack_h, allowed);
            end
            for (int i = 0; i < NPORT; i++) begin
                if (ack_h[i] === 1'b1 && allowed[i]) begin
                    d = ref_route(addr, hdr[i]);
                    checks++;
                    if (m_out_pre[d]) begin
                        errors++;
                        $display("FAIL rand_double_grant cycle %0d: input %0d granted output %0d, required output free", cyc, i, d);
                    end
                    m_in[i]  = 1;
                    m_dst[i] = d;
                    m_out[d] = 1;
                    done[i]  = 0;
                    req_h[i] = 1'b0;
                end
            end
            for (int i = 0; i < NPORT; i++) begin
                exp_in[i]  = m_in[i];
                exp_out[i] = m_out[i];
            end
            checks++;
            if (in_busy !== exp_in || out_busy !== exp_out) begin
                errors++;
                $display("FAIL rand_busy cycle %0d: in_busy=%b out_busy=%b required %b %b", cyc, in_busy, out_busy, exp_in, exp_out);
            end
            for (int i = 0; i < NPORT; i++) begin
                if (m_in[i]) begin
                    checks++;
                    if (ooi(i) !== m_dst[i] || ioo(int'(m_dst[i])) !== 3'(i)) begin
                        errors++;
                        $display("FAIL rand_tables cycle %0d in %0d: out_of_in=%0d in_of_out=%0d required %0d %0d",
                                 cyc, i, ooi(i), ioo(int'(m_dst[i])), m_dst[i], i);
                    end
                end
            end
        end
        pending = 0;
        for (int i = 0; i < NPORT; i++) if (active[i]) pending = 1;
        checks++;
        if (pending || in_busy !== '0 || out_busy !== '0) begin
            errors++;
            $display("FAIL rand_drain: packets still outstanding, in_busy=%b out_busy=%b required all served", in_busy, out_busy);
        end
        req_h = '0;
        pull  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        addr  = '0;
        req_h = '0;
        pull  = '0;
        for (int i = 0; i < NPORT; i++) hd[i] = '0;
        #1;
        reset = 1'b0;
        #2;
        test_reset();
        test_single_grant();
        test_packet_release();
        test_contention();
        test_zero_len();
        test_four_way();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
